seq_divider: RTL and testbench

- Sequential restoring divider; the inverse of the team's 8x8 -> 16-bit array multiplier.
- Divides a 16-bit dividend by an 8-bit divisor, giving an 8-bit quotient and an 8-bit remainder.
- Computes one quotient bit per clock under a start/done handshake.
- Sits in the 8-bit ALU beside the multiplier, selected by the ALU divide opcode.

---
 rtl/div_pkg.sv | 13 +
 rtl/seq_divider_if.sv | 24 ++
 rtl/seq_divider_div_step.sv | 21 ++
 rtl/seq_divider.sv | 108 ++++++++++
 tb/tb_seq_divider.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM encodings and
// the default operand width.
package div_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_divider_if.sv
// Start/done handshake and operand/result bundle between the ALU and the divider.
interface seq_divider_if #(parameter int WIDTH = div_pkg::DEFAULT_WIDTH);

    logic                 start;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 busy;
    logic                 done;
    logic                 div_by_zero;
    logic                 overflow;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero, overflow
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero, overflow
    );

endinterface

// File: rtl/seq_divider_div_step.sv
// One restoring-division step: compares the shifted partial remainder against
// the divisor and produces the trial difference.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH:0]   t,
    input  logic [WIDTH-1:0] divisor,
    output logic             ge,
    output logic [WIDTH-1:0] diff
);

    logic [WIDTH:0] sum;

    // Two's-complement subtract; the carry out means the low bits alone are >= divisor.
    assign sum  = {1'b0, t[WIDTH-1:0]} + {1'b0, ~divisor} + {{WIDTH{1'b0}}, 1'b1};
    assign ge   = t[WIDTH] | sum[WIDTH];
    assign diff = sum[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor, one quotient
// bit per clock, with divide-by-zero and quotient-overflow detection at start.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   r_reg, q_reg, divisor_reg;
    logic [CW-1:0]      count_reg;
    logic [WIDTH-1:0]   quotient_reg, remainder_reg;
    logic               div_by_zero_reg, overflow_reg;

    logic               accept, zero_div, too_big, last_iter;
    logic [WIDTH:0]     t;
    logic               ge;
    logic [WIDTH-1:0]   diff, r_next, q_next;

    assign accept    = bus.start && (state_reg == IDLE || state_reg == DONE);
    assign zero_div  = (bus.divisor == '0);
    assign too_big   = (bus.dividend[2*WIDTH-1:WIDTH] >= bus.divisor);
    assign last_iter = (count_reg == CW'(WIDTH - 1));

    assign t      = {r_reg, q_reg[WIDTH-1]};
    assign r_next = ge ? diff : t[WIDTH-1:0];
    assign q_next = {q_reg[WIDTH-2:0], ge};

    div_step #(.WIDTH(WIDTH)) u_step (
        .t       (t),
        .divisor (divisor_reg),
        .ge      (ge),
        .diff    (diff)
    );

    always_ff @(posedge clk) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (accept) state_next = (zero_div || too_big) ? DONE : RUN;
                else        state_next = IDLE;
            end
            RUN:     if (last_iter) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_reg == RUN);
        bus.done = (state_reg == DONE);
    end

    // Results are only touched on acceptance (error cases) or the final iteration.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg           <= '0;
            q_reg           <= '0;
            divisor_reg     <= '0;
            count_reg       <= '0;
            quotient_reg    <= '0;
            remainder_reg   <= '0;
            div_by_zero_reg <= 1'b0;
            overflow_reg    <= 1'b0;
        end else if (accept) begin
            divisor_reg     <= bus.divisor;
            div_by_zero_reg <= 1'b0;
            overflow_reg    <= 1'b0;
            if (zero_div) begin
                quotient_reg    <= '1;
                remainder_reg   <= bus.dividend[WIDTH-1:0];
                div_by_zero_reg <= 1'b1;
            end else if (too_big) begin
                quotient_reg  <= '1;
                remainder_reg <= '1;
                overflow_reg  <= 1'b1;
            end else begin
                r_reg     <= bus.dividend[2*WIDTH-1:WIDTH];
                q_reg     <= bus.dividend[WIDTH-1:0];
                count_reg <= '0;
            end
        end else if (state_reg == RUN) begin
            r_reg     <= r_next;
            q_reg     <= q_next;
            count_reg <= count_reg + 1'b1;
            if (last_iter) begin
                quotient_reg  <= q_next;
                remainder_reg <= r_next;
            end
        end
    end

    assign bus.quotient    = quotient_reg;
    assign bus.remainder   = remainder_reg;
    assign bus.div_by_zero = div_by_zero_reg;
    assign bus.overflow    = overflow_reg;

endmodule

// File: tb/tb_seq_divider.sv
// Directed checks for seq_divider: latency, results, error flags, reset abort
// and back-to-back operation.
module tb_seq_divider;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    seq_divider_if #(.WIDTH(8)) bus ();

    seq_divider #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands with start for exactly one edge (the acceptance edge).
    task automatic issue(input logic [15:0] dd, input logic [7:0] dv);
        bus.dividend = dd;
        bus.divisor  = dv;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero, bus.overflow} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got q=%h r=%h busy=%b done=%b dbz=%b ovf=%b, want all 0",
                     bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero, bus.overflow);
        end
    endtask

    task automatic test_normal();
        issue(16'h03E8, 8'h07);
        n_cmp++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL normal_busy: got %b want 1", bus.busy);
        end
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) begin
                n_cmp++;
                if (bus.done !== 1'b0) begin
                    n_fail++;
                    $display("FAIL normal_early_done: got %b want 0", bus.done);
                end
            end
        end
        n_cmp++;
        if ({bus.done, bus.busy, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow} !== {2'b10, 8'h8E, 8'h06, 2'b00}) begin
            n_fail++;
            $display("FAIL normal_result: got done=%b busy=%b q=%h r=%h dbz=%b ovf=%b, want done=1 busy=0 q=8e r=06 flags 0",
                     bus.done, bus.busy, bus.quotient, bus.remainder, bus.div_by_zero, bus.overflow);
        end
        $display("op 03e8/07 -> q=%h r=%h", bus.quotient, bus.remainder);
        tick();
        n_cmp++;
        if ({bus.done, bus.quotient, bus.remainder} !== {1'b0, 8'h8E, 8'h06}) begin
            n_fail++;
            $display("FAIL normal_hold: got done=%b q=%h r=%h, want done=0 q=8e r=06",
                     bus.done, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_max_and_sweep();
        logic [15:0] dd;
        logic [7:0]  dv, hi;
        logic [15:0] exp_q, exp_r;
        bit          seen;
        issue(16'hFE01, 8'hFF);
        for (int k = 0; k < 8; k++) tick();
        n_cmp++;
        if ({bus.done, bus.quotient, bus.remainder, bus.overflow} !== {1'b1, 8'hFF, 8'h00, 1'b0}) begin
            n_fail++;
            $display("FAIL max_result: got done=%b q=%h r=%h ovf=%b, want done=1 q=ff r=00 ovf=0",
                     bus.done, bus.quotient, bus.remainder, bus.overflow);
        end
        $display("op fe01/ff -> q=%h r=%h", bus.quotient, bus.remainder);
        tick();
        for (int i = 0; i < 24; i++) begin
            dv = 8'($urandom_range(1, 255));
            hi = 8'($urandom_range(0, int'(dv) - 1));
            dd = {hi, 8'($urandom_range(0, 255))};
            exp_q = dd / {8'h00, dv};
            exp_r = dd % {8'h00, dv};
            issue(dd, dv);
            seen = 1'b0;
            for (int c = 0; c < 20 && !seen; c++) begin
                if (bus.done === 1'b1) seen = 1'b1;
                else tick();
            end
            n_cmp++;
            if (!seen) begin
                n_fail++;
                $display("FAIL sweep_timeout: %h/%h no done within 20 cycles, want done", dd, dv);
            end else if ({bus.quotient, bus.remainder} !== {exp_q[7:0], exp_r[7:0]}
                         || ({8'h00, bus.quotient} * {8'h00, dv} + {8'h00, bus.remainder}) !== dd
                         || bus.remainder >= dv) begin
                n_fail++;
                $display("FAIL sweep_result: %h/%h got q=%h r=%h, want q=%h r=%h",
                         dd, dv, bus.quotient, bus.remainder, exp_q[7:0], exp_r[7:0]);
            end
            $display("op %h/%h -> q=%h r=%h", dd, dv, bus.quotient, bus.remainder);
            tick();
        end
    endtask

    task automatic test_div_zero();
        issue(16'h1234, 8'h00);
        n_cmp++;
        if ({bus.done, bus.busy, bus.div_by_zero, bus.overflow, bus.quotient, bus.remainder} !== {4'b1010, 8'hFF, 8'h34}) begin
            n_fail++;
            $display("FAIL div_zero: got done=%b busy=%b dbz=%b ovf=%b q=%h r=%h, want done=1 busy=0 dbz=1 ovf=0 q=ff r=34",
                     bus.done, bus.busy, bus.div_by_zero, bus.overflow, bus.quotient, bus.remainder);
        end
        $display("op 1234/00 -> q=%h r=%h dbz=%b", bus.quotient, bus.remainder, bus.div_by_zero);
        tick();
        n_cmp++;
        if ({bus.done, bus.busy, bus.div_by_zero} !== 3'b001) begin
            n_fail++;
            $display("FAIL div_zero_after: got done=%b busy=%b dbz=%b, want done=0 busy=0 dbz=1",
                     bus.done, bus.busy, bus.div_by_zero);
        end
    endtask

    task automatic test_overflow();
        issue(16'h0100, 8'h01);
        n_cmp++;
        if ({bus.done, bus.busy, bus.overflow, bus.div_by_zero, bus.quotient, bus.remainder} !== {4'b1010, 8'hFF, 8'hFF}) begin
            n_fail++;
            $display("FAIL overflow: got done=%b busy=%b ovf=%b dbz=%b q=%h r=%h, want done=1 busy=0 ovf=1 dbz=0 q=ff r=ff",
                     bus.done, bus.busy, bus.overflow, bus.div_by_zero, bus.quotient, bus.remainder);
        end
        $display("op 0100/01 -> q=%h r=%h ovf=%b", bus.quotient, bus.remainder, bus.overflow);
        tick();
        issue(16'h0064, 8'h0A);
        n_cmp++;
        if ({bus.overflow, bus.busy} !== 2'b01) begin
            n_fail++;
            $display("FAIL overflow_clear: got ovf=%b busy=%b, want ovf=0 busy=1", bus.overflow, bus.busy);
        end
        for (int k = 0; k < 8; k++) tick();
        n_cmp++;
        if ({bus.done, bus.quotient, bus.remainder} !== {1'b1, 8'h0A, 8'h00}) begin
            n_fail++;
            $display("FAIL overflow_next: got done=%b q=%h r=%h, want done=1 q=0a r=00",
                     bus.done, bus.quotient, bus.remainder);
        end
        $display("op 0064/0a -> q=%h r=%h", bus.quotient, bus.remainder);
        tick();
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        issue(16'h03E8, 8'h07);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero, bus.overflow} !== 20'h0) begin
            n_fail++;
            $display("FAIL abort_outputs: got q=%h r=%h busy=%b done=%b dbz=%b ovf=%b, want all 0",
                     bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero, bus.overflow);
        end
        saw_done = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) saw_done = 1'b1;
        end
        n_cmp++;
        if (saw_done !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: got activity=%b after reset, want 0", saw_done);
        end
        issue(16'h0064, 8'h0A);
        for (int k = 0; k < 8; k++) tick();
        n_cmp++;
        if ({bus.done, bus.quotient, bus.remainder} !== {1'b1, 8'h0A, 8'h00}) begin
            n_fail++;
            $display("FAIL abort_restart: got done=%b q=%h r=%h, want done=1 q=0a r=00",
                     bus.done, bus.quotient, bus.remainder);
        end
        $display("op 0064/0a -> q=%h r=%h", bus.quotient, bus.remainder);
        tick();
    endtask

    task automatic test_back_to_back();
        bus.dividend = 16'h03E8;
        bus.divisor  = 8'h07;
        bus.start    = 1'b1;
        tick();
        // Operand changes while running must not be sampled.
        bus.dividend = 16'h0000;
        bus.divisor  = 8'h01;
        for (int k = 0; k < 8; k++) tick();
        n_cmp++;
        if ({bus.done, bus.quotient, bus.remainder} !== {1'b1, 8'h8E, 8'h06}) begin
            n_fail++;
            $display("FAIL b2b_first: got done=%b q=%h r=%h, want done=1 q=8e r=06",
                     bus.done, bus.quotient, bus.remainder);
        end
        $display("op 03e8/07 -> q=%h r=%h", bus.quotient, bus.remainder);
        bus.dividend = 16'hFE01;
        bus.divisor  = 8'hFF;
        tick();
        bus.start = 1'b0;
        n_cmp++;
        if ({bus.busy, bus.done, bus.quotient, bus.remainder} !== {2'b10, 8'h8E, 8'h06}) begin
            n_fail++;
            $display("FAIL b2b_no_bubble: got busy=%b done=%b q=%h r=%h, want busy=1 done=0 q=8e r=06",
                     bus.busy, bus.done, bus.quotient, bus.remainder);
        end
        for (int k = 0; k < 8; k++) tick();
        n_cmp++;
        if ({bus.done, bus.quotient, bus.remainder} !== {1'b1, 8'hFF, 8'h00}) begin
            n_fail++;
            $display("FAIL b2b_second: got done=%b q=%h r=%h, want done=1 q=ff r=00",
                     bus.done, bus.quotient, bus.remainder);
        end
        $display("op fe01/ff -> q=%h r=%h", bus.quotient, bus.remainder);
        tick();
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        test_reset();
        test_normal();
        test_max_and_sweep();
        test_div_zero();
        test_overflow();
        test_reset_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
